// File: rtl/core_mc_pkg.sv
// Shared types for the multi-cycle core: sequencer states, jump types,
// ALU operations, operand selects and the instruction decoder.
package core_mc_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [2:0] J_TYPE_NOP = 3'd0;
  localparam logic [2:0] J_TYPE_BEQ = 3'd1;
  localparam logic [2:0] J_TYPE_JAL = 3'd2;
  localparam logic [2:0] J_TYPE_JR  = 3'd3;
  localparam logic [2:0] J_TYPE_J   = 3'd4;

  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_PASSB
  } alu_op_t;

  // Second ALU operand: register rt, sign-extended immediate, or pc+4 (JAL link)
  typedef enum logic [1:0] {SSEL_RS2, SSEL_IMM, SSEL_PC4} ssel_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_reg;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] target;
    alu_op_t     alu_op;
    ssel_t       ssel;
    logic [2:0]  jtype;
    logic        we_regfile;
    logic        we_dmem;
    logic        is_load;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d        = '0;
    d.rs     = ir[25:21];
    d.rt     = ir[20:16];
    d.shamt  = ir[10:6];
    d.imm16  = ir[15:0];
    d.target = ir[25:0];
    d.alu_op = ALU_ADD;
    d.ssel   = SSEL_RS2;
    d.jtype  = J_TYPE_NOP;
    case (ir[31:26])
      6'h00: begin
        d.wr_reg     = ir[15:11];
        d.we_regfile = 1'b1;
        case (ir[5:0])
          6'h00: d.alu_op = ALU_SLL;
          6'h08: begin d.jtype = J_TYPE_JR; d.we_regfile = 1'b0; end
          6'h20: d.alu_op = ALU_ADD;
          6'h22: d.alu_op = ALU_SUB;
          6'h24: d.alu_op = ALU_AND;
          6'h25: d.alu_op = ALU_OR;
          6'h2A: d.alu_op = ALU_SLT;
          default: d.we_regfile = 1'b0;
        endcase
      end
      6'h02: d.jtype = J_TYPE_J;
      6'h03: begin
        d.jtype      = J_TYPE_JAL;
        d.wr_reg     = 5'd31;
        d.we_regfile = 1'b1;
        d.alu_op     = ALU_PASSB;
        d.ssel       = SSEL_PC4;
      end
      6'h04: begin d.jtype = J_TYPE_BEQ; d.alu_op = ALU_SUB; end
      6'h08: begin d.wr_reg = ir[20:16]; d.we_regfile = 1'b1; d.ssel = SSEL_IMM; end
      6'h23: begin
        d.wr_reg     = ir[20:16];
        d.we_regfile = 1'b1;
        d.is_load    = 1'b1;
        d.ssel       = SSEL_IMM;
      end
      6'h2B: begin d.we_dmem = 1'b1; d.ssel = SSEL_IMM; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/core_mc_ctrl.sv
// Instruction sequencer for the multi-cycle core.
//   state | meaning
//   FETCH | read instruction at pc, wait for mem_ready
//   EXEC  | decode/ALU, latch alu_q, sdata, next_pc
//   MEM   | data load/store at alu_q, wait for mem_ready
//   WB    | register write-back, commit pc and retire
// Ports: clk, rst (async, active-high); mem_ready in; is_load/we_dmem from
// decode; state, mem_req, mem_we and datapath latch enables out.
module core_mc_ctrl
  import core_mc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   mem_ready,
  input  logic   is_load,
  input  logic   we_dmem,
  output state_t state,
  output logic   mem_req,
  output logic   mem_we,
  output logic   ir_en,
  output logic   exec_en,
  output logic   mdr_en,
  output logic   wb_en,
  output logic   commit
);

  logic xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (xfer) state <= S_EXEC;
        S_EXEC:  state <= (is_load || we_dmem) ? S_MEM : S_WB;
        S_MEM:   if (xfer) state <= is_load ? S_WB : S_FETCH;
        S_WB:    state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Request is decoded from the state register so a zero-wait memory costs
  // one cycle per memory state; rst gates it so an abort drops it at once.
  assign mem_req = ~rst & ((state == S_FETCH) || (state == S_MEM));
  assign xfer    = mem_req & mem_ready;
  assign mem_we  = mem_req & (state == S_MEM) & we_dmem;
  assign ir_en   = xfer & (state == S_FETCH);
  assign exec_en = (state == S_EXEC);
  assign mdr_en  = xfer & (state == S_MEM) & is_load;
  assign wb_en   = (state == S_WB);
  // Stores retire on their memory handshake; everything else in WB.
  assign commit  = wb_en | (xfer & (state == S_MEM) & ~is_load);

endmodule

// File: rtl/core_top_mc.sv
// Multi-cycle core: FETCH/EXEC/MEM/WB over one shared memory port with a
// req/ready handshake. Holds the datapath registers, decode, register file
// and ALU; sequencing lives in core_mc_ctrl.
// Ports: clk, rst (async, active-high); mem_req/mem_we/mem_addr/mem_wdata
// out, mem_ready/mem_rdata in; dbg_pc (pc register), retired (instr count).
module core_top_mc
  import core_mc_pkg::*;
#(
  parameter int                DWIDTH    = 32,
  parameter int                AWIDTH    = 32,
  parameter logic [AWIDTH-1:0] RESET_PC  = '0,
  parameter int                CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AWIDTH-1:0]    mem_addr,
  output logic [DWIDTH-1:0]    mem_wdata,
  input  logic                 mem_ready,
  input  logic [DWIDTH-1:0]    mem_rdata,
  output logic [AWIDTH-1:0]    dbg_pc,
  output logic [CNT_WIDTH-1:0] retired
);

  state_t            state;
  logic              ir_en, exec_en, mdr_en, wb_en, commit;
  logic [AWIDTH-1:0] pc, next_pc, pc4, br_target, jump_addr, npc;
  logic [31:0]       ir;
  logic [DWIDTH-1:0] mdr, alu_q, sdata;
  logic [DWIDTH-1:0] rs1_v, rs2_v, imm_ext, alu_b, alu_y, wb_data;
  logic [DWIDTH-1:0] rf [32];
  logic              zero, rf_we;
  dec_t              dec;

  assign dec = decode(ir);

  core_mc_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .mem_ready (mem_ready),
    .is_load   (dec.is_load),
    .we_dmem   (dec.we_dmem),
    .state     (state),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_en     (ir_en),
    .exec_en   (exec_en),
    .mdr_en    (mdr_en),
    .wb_en     (wb_en),
    .commit    (commit)
  );

  // Register file: $0 reads as zero and writes to it are dropped.
  assign rs1_v   = (dec.rs == 5'd0) ? '0 : rf[dec.rs];
  assign rs2_v   = (dec.rt == 5'd0) ? '0 : rf[dec.rt];
  assign wb_data = dec.is_load ? mdr : alu_q;
  assign rf_we   = wb_en & dec.we_regfile & (dec.wr_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (rf_we) rf[dec.wr_reg] <= wb_data;
  end

  assign imm_ext = {{(DWIDTH-16){dec.imm16[15]}}, dec.imm16};

  always_comb begin
    alu_b = rs2_v;
    case (dec.ssel)
      SSEL_IMM: alu_b = imm_ext;
      SSEL_PC4: alu_b = DWIDTH'(pc4);
      default:  alu_b = rs2_v;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (dec.alu_op)
      ALU_ADD:   alu_y = rs1_v + alu_b;
      ALU_SUB:   alu_y = rs1_v - alu_b;
      ALU_AND:   alu_y = rs1_v & alu_b;
      ALU_OR:    alu_y = rs1_v | alu_b;
      ALU_SLT:   alu_y = {{(DWIDTH-1){1'b0}}, $signed(rs1_v) < $signed(alu_b)};
      ALU_SLL:   alu_y = alu_b << dec.shamt;
      ALU_PASSB: alu_y = alu_b;
      default:   alu_y = '0;
    endcase
  end

  assign zero = (alu_y == '0);

  // All PC arithmetic is AWIDTH bits and wraps naturally.
  assign pc4       = pc + AWIDTH'(PC_STEP);
  assign br_target = pc4 + {{(AWIDTH-18){dec.imm16[15]}}, dec.imm16, 2'b00};
  // Jump keeps the upper bits of pc+4 and replaces the low 28 bits.
  assign jump_addr = (pc4 & ~AWIDTH'(28'hFFF_FFFF)) | AWIDTH'({dec.target, 2'b00});

  always_comb begin
    npc = pc4;
    case (dec.jtype)
      J_TYPE_BEQ: npc = zero ? br_target : pc4;
      J_TYPE_JAL: npc = jump_addr;
      J_TYPE_J:   npc = jump_addr;
      J_TYPE_JR:  npc = AWIDTH'(rs1_v);
      default:    npc = pc4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      next_pc <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      alu_q   <= '0;
      sdata   <= '0;
      retired <= '0;
    end else begin
      if (ir_en) ir <= mem_rdata[31:0];
      if (exec_en) begin
        alu_q   <= alu_y;
        sdata   <= rs2_v;
        next_pc <= npc;
      end
      if (mdr_en) mdr <= mem_rdata;
      if (commit) begin
        pc      <= next_pc;
        retired <= retired + CNT_WIDTH'(1);
      end
    end
  end

  // Address and store data come from registers that only change on a
  // handshake, so they hold steady while memory stalls.
  assign mem_addr  = (state == S_MEM) ? AWIDTH'(alu_q) : pc;
  assign mem_wdata = sdata;
  assign dbg_pc    = pc;

endmodule
